// File: rtl/data_sram_responder.sv
// Data-SRAM responder: word-organised memory answering one load/store at a time
// with an addr_ok/data_ok handshake. Define DELAY_RAND_EN for LFSR-driven latency.
module data_sram_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [3:0]        lat_m1;
    logic              wr_q;
    logic [3:0]        wstrb_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic              accept;
    logic [31:0]       mem [2**ADDR_W];

    // Address bits outside the word index are deliberately ignored (wrap-around).
    logic unused_addr;
    assign unused_addr = ^{data_addr[31:ADDR_W+2], data_addr[1:0]};

`ifdef DELAY_RAND_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    assign lat_m1 = {2'b00, lfsr_q[1:0]};
`else
    assign lat_m1 = 4'(LATENCY - 1);
`endif

    assign accept = (state_q == StIdle) && data_req && !reset;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (data_req) begin
                    cnt_d   = lat_m1;
                    state_d = (lat_m1 == 4'd0) ? StResp : StWait;
                end
            end
            StWait: begin
                // Leave one cycle early so data_ok lands exactly LATENCY cycles after accept.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            wstrb_q <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= data_wr;
                wstrb_q <= data_wstrb;
                idx_q   <= data_addr[ADDR_W+1:2];
                wdata_q <= data_wdata;
            end
        end
    end

    // Memory is not reset; a store reaching RESP in a reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (!reset && (state_q == StResp) && wr_q) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        data_addr_ok = (state_q == StIdle) && !reset;
        data_data_ok = (state_q == StResp) && !reset;
        busy         = (state_q != StIdle) && !reset;
        data_rdata   = 32'd0;
        if (data_data_ok && !wr_q) begin
            data_rdata = mem[idx_q];
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: two instances (LATENCY 1 and 3) against a
// transaction-level model of the memory and handshake timing.
module tb_data_sram_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req      [2];
    logic        wr       [2];
    logic [3:0]  wstrb    [2];
    logic [31:0] addr     [2];
    logic [31:0] wdata    [2];
    logic        addr_ok  [2];
    logic        data_ok  [2];
    logic [31:0] rdata    [2];
    logic        busy     [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        data_sram_responder #(
            .ADDR_W (10),
            .LATENCY((g == 0) ? 1 : 3)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .data_req    (req[g]),
            .data_wr     (wr[g]),
            .data_wstrb  (wstrb[g]),
            .data_addr   (addr[g]),
            .data_wdata  (wdata[g]),
            .data_addr_ok(addr_ok[g]),
            .data_data_ok(data_ok[g]),
            .data_rdata  (rdata[g]),
            .busy        (busy[g])
        );
    end

    task automatic check(input string name, input int i, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] cycle %0d: got %h expected %h", name, i, cyc, act, exp);
        end
    endtask

    function automatic int lat_lo(input int i);
`ifdef DELAY_RAND_EN
        return 1;
`else
        return (i == 0) ? 1 : 3;
`endif
    endfunction

    function automatic int lat_hi(input int i);
`ifdef DELAY_RAND_EN
        return 4;
`else
        return (i == 0) ? 1 : 3;
`endif
    endfunction

    // Model state: one outstanding request per instance plus a byte-level memory image.
    bit          m_out  [2];
    int          m_acc  [2];
    bit          m_wr   [2];
    logic [3:0]  m_strb [2];
    int          m_idx  [2];
    logic [31:0] m_data [2];
    logic [7:0]  mb     [int];

    bit          s_reset;
    bit          s_req  [2];
    bit          s_dok  [2];
    bit          s_wr   [2];
    logic [3:0]  s_strb [2];
    logic [31:0] s_addr [2];
    logic [31:0] s_data [2];

    initial begin
        for (int i = 0; i < 2; i++) m_out[i] = 1'b0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (s_reset) begin
                    m_out[i] = 1'b0;
                end else if (m_out[i] && s_dok[i]) begin
                    if (m_wr[i]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (m_strb[i][b]) mb[i*65536 + m_idx[i]*4 + b] = m_data[i][8*b +: 8];
                        end
                    end
                    m_out[i] = 1'b0;
                end else if (!m_out[i] && s_req[i]) begin
                    m_out[i]  = 1'b1;
                    m_acc[i]  = cyc;
                    m_wr[i]   = s_wr[i];
                    m_strb[i] = s_strb[i];
                    m_idx[i]  = int'((s_addr[i] >> 2) & 32'h3FF);
                    m_data[i] = s_data[i];
                end
            end
            cyc++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            s_reset = reset;
            for (int i = 0; i < 2; i++) begin
                int          age;
                bit          known;
                logic [31:0] exp_rd;
                s_req[i]  = req[i];
                s_dok[i]  = data_ok[i];
                s_wr[i]   = wr[i];
                s_strb[i] = wstrb[i];
                s_addr[i] = addr[i];
                s_data[i] = wdata[i];
                if (reset) begin
                    check("rst_addr_ok", i, 32'(addr_ok[i]), 32'd0);
                    check("rst_data_ok", i, 32'(data_ok[i]), 32'd0);
                    check("rst_busy", i, 32'(busy[i]), 32'd0);
                    check("rst_rdata", i, rdata[i], 32'd0);
                end else begin
                    age = cyc - m_acc[i];
                    check("addr_ok", i, 32'(addr_ok[i]), 32'(!m_out[i]));
                    check("busy", i, 32'(busy[i]), 32'(m_out[i]));
                    if (!(m_out[i] && age >= lat_lo(i) && age < lat_hi(i)))
                        check("data_ok", i, 32'(data_ok[i]), 32'(m_out[i] && age == lat_hi(i)));
                    exp_rd = 32'd0;
                    known  = 1'b1;
                    if (data_ok[i] && m_out[i] && !m_wr[i]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (mb.exists(i*65536 + m_idx[i]*4 + b))
                                exp_rd[8*b +: 8] = mb[i*65536 + m_idx[i]*4 + b];
                            else
                                known = 1'b0;
                        end
                    end
                    if (known) check("rdata", i, rdata[i], exp_rd);
                end
            end
        end
    end

    logic [31:0] t_rdata [2];
    int          t_lat   [2];

    // Issue the same request to both instances; each drops req once it is accepted.
    task automatic txn(input logic w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] d);
        bit took [2];
        bit done [2];
        int acc  [2];
        for (int i = 0; i < 2; i++) begin
            wr[i] = w; wstrb[i] = s; addr[i] = a; wdata[i] = d; req[i] = 1'b1;
            done[i] = 1'b0; acc[i] = 0; t_rdata[i] = 32'd0; t_lat[i] = 0;
        end
        for (int n = 0; n < 40 && !(done[0] && done[1]); n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                took[i] = req[i] && addr_ok[i];
                if (took[i]) acc[i] = cyc;
                if (!req[i] && !done[i] && data_ok[i]) begin
                    done[i]    = 1'b1;
                    t_rdata[i] = rdata[i];
                    t_lat[i]   = cyc - acc[i];
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) if (took[i]) req[i] = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0;
            check("txn_done", i, 32'(done[i]), 32'd1);
            check("latency_range", i, 32'(t_lat[i] >= lat_lo(i) && t_lat[i] <= lat_hi(i)), 32'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nr;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; wr[i] = 1'b0; wstrb[i] = 4'd0; addr[i] = 32'd0; wdata[i] = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("post_rst_addr_ok", i, 32'(addr_ok[i]), 32'd1);
            check("post_rst_data_ok", i, 32'(data_ok[i]), 32'd0);
            check("post_rst_busy", i, 32'(busy[i]), 32'd0);
            check("post_rst_rdata", i, rdata[i], 32'd0);
        end
        @(posedge clk);
        #1;

        txn(1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
`ifndef DELAY_RAND_EN
        check("store_latency", 0, 32'(t_lat[0]), 32'd1);
        check("store_latency", 1, 32'(t_lat[1]), 32'd3);
`endif
        check("store_rdata_zero", 0, t_rdata[0], 32'd0);
        txn(1'b0, 4'hF, 32'h0000_0010, 32'd0);
        for (int i = 0; i < 2; i++) check("load_full", i, t_rdata[i], 32'hDEAD_BEEF);

        txn(1'b1, 4'b0010, 32'h0000_0010, 32'h0000_AA00);
        txn(1'b0, 4'h0, 32'h0000_0010, 32'd0);
        for (int i = 0; i < 2; i++) check("load_merge", i, t_rdata[i], 32'hDEAD_AAEF);

        txn(1'b1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF);
        txn(1'b0, 4'hF, 32'h0000_0013, 32'd0);
        for (int i = 0; i < 2; i++) check("load_strb0", i, t_rdata[i], 32'hDEAD_AAEF);

        txn(1'b1, 4'hF, 32'h0000_1004, 32'h1234_5678);
        txn(1'b0, 4'hF, 32'h0000_0004, 32'd0);
        for (int i = 0; i < 2; i++) check("load_wrap", i, t_rdata[i], 32'h1234_5678);

`ifndef DELAY_RAND_EN
        // LATENCY=3 instance: request held through the busy window.
        wr[1] = 1'b0; addr[1] = 32'h0000_0010; req[1] = 1'b1;
        @(negedge clk);
        check("b2b_accept", 1, 32'(addr_ok[1]), 32'd1);
        @(posedge clk);
        #1 addr[1] = 32'h0000_0004;
        @(negedge clk);
        check("b2b_t1_addr_ok", 1, 32'(addr_ok[1]), 32'd0);
        check("b2b_t1_data_ok", 1, 32'(data_ok[1]), 32'd0);
        @(negedge clk);
        check("b2b_t2_addr_ok", 1, 32'(addr_ok[1]), 32'd0);
        check("b2b_t2_data_ok", 1, 32'(data_ok[1]), 32'd0);
        @(negedge clk);
        check("b2b_t3_addr_ok", 1, 32'(addr_ok[1]), 32'd0);
        check("b2b_t3_data_ok", 1, 32'(data_ok[1]), 32'd1);
        check("b2b_t3_rdata", 1, rdata[1], 32'hDEAD_AAEF);
        @(negedge clk);
        check("b2b_t4_accept", 1, 32'(addr_ok[1]), 32'd1);
        @(posedge clk);
        #1 req[1] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
`endif

        txn(1'b1, 4'hF, 32'h0000_0020, 32'h1111_2222);
        wr[1] = 1'b1; wstrb[1] = 4'hF; addr[1] = 32'h0000_0020; wdata[1] = 32'h3333_4444;
        req[1] = 1'b1;
        @(negedge clk);
        check("rst_store_accept", 1, 32'(addr_ok[1]), 32'd1);
        @(posedge clk);
        #1 req[1] = 1'b0; reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        txn(1'b0, 4'hF, 32'h0000_0020, 32'd0);
        for (int i = 0; i < 2; i++) check("load_after_rst", i, t_rdata[i], 32'h1111_2222);

`ifdef DELAY_RAND_EN
        nr = 200;
`else
        nr = 40;
`endif
        for (int k = 0; k < 8; k++) txn(1'b1, 4'hF, 32'(k * 4), $urandom);
        for (int n = 0; n < nr; n++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 3)) << 12)
                | 32'($urandom_range(0, 3));
            txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
